// File: rtl/io_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_mmio_ctrl
// Purpose  : Memory-mapped I/O block for the core data port: UART TX/RX
//            handshakes, cycle/instret counters, one-cycle registered reads.
// Options  : IO_RX_FIFO_EN selects an RX_FIFO_DEPTH-entry RX FIFO instead of
//            the single-entry RX buffer.
// Revision : 1.0 - initial release
// ============================================================================
module io_mmio_ctrl #(
    parameter int CNT_WIDTH     = 32,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_load,
    input  logic        iowea,
    input  logic [3:0]  wea,
    input  logic [4:0]  adr,
    input  logic [31:0] din_io,
    input  logic        inst_retire,
    output logic [31:0] dout_io,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam logic [4:0] ADR_STATUS = 5'h00;
    localparam logic [4:0] ADR_RX     = 5'h01;
    localparam logic [4:0] ADR_TX     = 5'h02;
    localparam logic [4:0] ADR_CYCLE  = 5'h04;
    localparam logic [4:0] ADR_INSTR  = 5'h05;
    localparam logic [4:0] ADR_CLEAR  = 5'h06;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    logic                 store;
    logic                 st_tx;
    logic                 st_clr;
    logic                 ld_status;
    logic                 ld_rx;
    tx_state_t            tx_state;
    logic                 tx_drop;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] instr_cnt;
    logic                 rx_avail;
    logic [7:0]           rx_head;
    logic [31:0]          rd_data;
    logic [23:0]          unused_din;

    assign store      = iowea && (|wea);
    assign st_tx      = store && (adr == ADR_TX);
    assign st_clr     = store && (adr == ADR_CLEAR);
    assign ld_status  = io_load && (adr == ADR_STATUS);
    assign ld_rx      = io_load && (adr == ADR_RX);
    assign unused_din = din_io[31:8];

    // TX sequencer; the byte and valid stay frozen until the UART takes them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state      <= TX_IDLE;
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
            tx_drop       <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (st_tx) begin
                        uart_tx_data  <= din_io[7:0];
                        uart_tx_valid <= 1'b1;
                        tx_state      <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (uart_tx_ready) begin
                        uart_tx_valid <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end
                end
                default: begin
                    uart_tx_valid <= 1'b0;
                    tx_state      <= TX_IDLE;
                end
            endcase

            if (st_tx && (tx_state == TX_BUSY)) begin
                tx_drop <= 1'b1;
            end else if (ld_status) begin
                tx_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (st_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (inst_retire) begin
                instr_cnt <= instr_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef IO_RX_FIFO_EN
    localparam int              PTR_W     = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W + 1)'(RX_FIFO_DEPTH);

    logic [7:0]       fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   rx_count;
    logic             rx_push;
    logic             rx_pop;

    assign uart_rx_ready = (rx_count != FIFO_FULL);
    assign rx_avail      = (rx_count != '0);
    assign rx_head       = fifo_mem[rd_ptr];
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    assign rx_pop        = ld_rx && rx_avail;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            fifo_mem[wr_ptr] <= uart_rx_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (PTR_W + 1)'(1);
                2'b01:   rx_count <= rx_count - (PTR_W + 1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end
`else
    logic        rx_full;
    logic [7:0]  rx_byte;
    logic [31:0] unused_depth;

    assign uart_rx_ready = !rx_full;
    assign rx_avail      = rx_full;
    assign rx_head       = rx_byte;
    assign unused_depth  = RX_FIFO_DEPTH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_full <= 1'b0;
            rx_byte <= 8'h00;
        end else if (uart_rx_valid && !rx_full) begin
            rx_byte <= uart_rx_data;
            rx_full <= 1'b1;
        end else if (ld_rx && rx_full) begin
            rx_full <= 1'b0;
        end
    end
`endif

    always_comb begin
        rd_data = 32'h0;
        case (adr)
            ADR_STATUS: rd_data = {29'h0, tx_drop, rx_avail, (tx_state == TX_IDLE)};
            ADR_RX:     rd_data = rx_avail ? {24'h0, rx_head} : 32'h0;
            ADR_CYCLE:  rd_data = 32'(cycle_cnt);
            ADR_INSTR:  rd_data = 32'(instr_cnt);
            default:    rd_data = 32'h0;
        endcase
    end

    // Read data lands one cycle after the strobe, like a synchronous BRAM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_io <= 32'h0;
        end else if (io_load) begin
            dout_io <= rd_data;
        end
    end

endmodule
`default_nettype wire
